// File: rtl/run_ctrl.sv
// Run controller: sequences a CPU core through reset, a watchdog-bounded run and a
// four-phase done handshake with the host. All outputs are registered (Moore).
module run_ctrl #(
    parameter int CW      = 16,
    parameter int RST_CYC = 2,
    parameter int TMAX    = 4000
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          req,
    input  logic          core_done,
    output logic          core_reset,
    output logic          core_en,
    output logic          busy,
    output logic          done,
    output logic          timeout,
    output logic [CW-1:0] cycles
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RST  = 2'd1,
        RUN  = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam logic [CW-1:0] TMAX_C = CW'(TMAX);
    localparam logic [7:0]    HOLD_C = 8'(RST_CYC);
    localparam logic [CW-1:0] ONE_C  = {{(CW-1){1'b0}}, 1'b1};

    state_t        state_r;
    state_t        state_nx_s;
    logic [7:0]    hold_r;
    logic [7:0]    hold_nx_s;
    logic [CW-1:0] cycles_r;
    logic [CW-1:0] cycles_nx_s;
    logic [CW-1:0] cycles_inc_s;
    logic          timeout_r;
    logic          timeout_nx_s;
    logic          core_reset_r;
    logic          core_en_r;
    logic          busy_r;
    logic          done_r;

    // Next-state, hold countdown, run counter and watchdog decision.
    always_comb begin
        state_nx_s   = state_r;
        hold_nx_s    = hold_r;
        cycles_nx_s  = cycles_r;
        timeout_nx_s = timeout_r;
        cycles_inc_s = cycles_r + ONE_C;
        case (state_r)
            IDLE: begin
                if (req) begin
                    state_nx_s   = RST;
                    hold_nx_s    = HOLD_C;
                    cycles_nx_s  = {CW{1'b0}};
                    timeout_nx_s = 1'b0;
                end else begin
                    state_nx_s = IDLE;
                end
            end
            // Entry cycle plus RST_CYC counted cycles keep the core in reset.
            RST: begin
                if (hold_r == 8'd0) begin
                    state_nx_s = RUN;
                end else begin
                    hold_nx_s = hold_r - 8'd1;
                end
            end
            RUN: begin
                cycles_nx_s = cycles_inc_s;
                if (core_done) begin
                    state_nx_s   = DONE;
                    timeout_nx_s = 1'b0;
                end else if (cycles_inc_s == TMAX_C) begin
                    state_nx_s   = DONE;
                    timeout_nx_s = 1'b1;
                end else begin
                    state_nx_s = RUN;
                end
            end
            DONE: begin
                if (!req) begin
                    state_nx_s = IDLE;
                end else begin
                    state_nx_s = DONE;
                end
            end
            default: begin
                state_nx_s = IDLE;
            end
        endcase
    end

    // State, counters and output flags; outputs are decoded from the next state so
    // they line up with the state register without any input-to-output path.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r      <= IDLE;
            hold_r       <= 8'd0;
            cycles_r     <= {CW{1'b0}};
            timeout_r    <= 1'b0;
            core_reset_r <= 1'b1;
            core_en_r    <= 1'b0;
            busy_r       <= 1'b0;
            done_r       <= 1'b0;
        end else begin
            state_r      <= state_nx_s;
            hold_r       <= hold_nx_s;
            cycles_r     <= cycles_nx_s;
            timeout_r    <= timeout_nx_s;
            core_reset_r <= (state_nx_s != RUN);
            core_en_r    <= (state_nx_s == RUN);
            busy_r       <= (state_nx_s == RST) || (state_nx_s == RUN);
            done_r       <= (state_nx_s == DONE);
        end
    end

    assign core_reset = core_reset_r;
    assign core_en    = core_en_r;
    assign busy       = busy_r;
    assign done       = done_r;
    assign timeout    = timeout_r;
    assign cycles     = cycles_r;

endmodule

// File: tb/tb_run_ctrl.sv
// Randomized and directed bench for run_ctrl against a start-time based reference model.
module tb_run_ctrl;

    localparam int CW      = 8;
    localparam int RST_CYC = 2;
    localparam int TMAX    = 20;

    logic          clk = 1'b0;
    logic          reset;
    logic          req;
    logic          core_done;
    logic          core_reset;
    logic          core_en;
    logic          busy;
    logic          done;
    logic          timeout;
    logic [CW-1:0] cycles;

    int total = 0;
    int bad   = 0;

    // Reference model: mode 0 = waiting, 1 = started, 2 = finished.
    // m_n counts edges since the start edge; RUN edges are those after the core leaves reset.
    int m_mode = 0;
    int m_n    = 0;
    int m_cyc  = 0;
    bit m_to   = 1'b0;

    run_ctrl #(.CW(CW), .RST_CYC(RST_CYC), .TMAX(TMAX)) dut (
        .clk        (clk),
        .reset      (reset),
        .req        (req),
        .core_done  (core_done),
        .core_reset (core_reset),
        .core_en    (core_en),
        .busy       (busy),
        .done       (done),
        .timeout    (timeout),
        .cycles     (cycles)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] dut_vec();
        return {19'd0, core_reset, core_en, busy, done, timeout, cycles};
    endfunction

    function automatic logic [31:0] exp_vec();
        logic in_run;
        logic [4:0] flags;
        logic [7:0] cyc8;
        in_run = (m_mode == 1) && (m_n >= RST_CYC + 1);
        case (m_mode)
            1:       flags = {!in_run, in_run, 1'b1, 1'b0, m_to};
            2:       flags = {1'b1, 1'b0, 1'b0, 1'b1, m_to};
            default: flags = {1'b1, 1'b0, 1'b0, 1'b0, m_to};
        endcase
        cyc8 = 8'(m_cyc);
        return {19'd0, flags, cyc8};
    endfunction

    task automatic model_edge(input bit r, input bit d);
        case (m_mode)
            0: if (r) begin
                m_mode = 1; m_n = 0; m_cyc = 0; m_to = 1'b0;
            end
            1: begin
                m_n++;
                if (m_n >= RST_CYC + 2) begin
                    m_cyc = m_n - RST_CYC - 1;
                    if (d) begin
                        m_mode = 2; m_to = 1'b0;
                    end else if (m_cyc == TMAX) begin
                        m_mode = 2; m_to = 1'b1;
                    end
                end
            end
            default: if (!r) m_mode = 0;
        endcase
    endtask

    task automatic model_reset();
        m_mode = 0; m_n = 0; m_cyc = 0; m_to = 1'b0;
    endtask

    task automatic step(input bit r, input bit d, input string tag);
        req = r;
        core_done = d;
        @(posedge clk);
        model_edge(r, d);
        #1;
        check_eq(tag, dut_vec(), exp_vec());
    endtask

    task automatic async_reset(input string tag);
        #2 reset = 1'b1;
        model_reset();
        #1;
        check_eq(tag, dut_vec(), exp_vec());
        check_eq({tag, "_cyc"}, 32'(cycles), 32'd0);
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        bit rq;
        reset = 1'b0;
        req = 1'b0;
        core_done = 1'b0;
        #2 reset = 1'b1;
        #1;
        check_eq("rst_state", dut_vec(), {19'd0, 5'b10000, 8'd0});
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        step(1'b0, 1'b0, "idle");

        // Normal run: done on the 5th RUN edge.
        step(1'b1, 1'b0, "n_start");
        step(1'b1, 1'b0, "n_rst1");
        step(1'b1, 1'b0, "n_rst2");
        step(1'b1, 1'b0, "n_enter");
        check_eq("n_en_edge3", 32'(core_en), 32'd1);
        repeat (4) step(1'b1, 1'b0, "n_run");
        step(1'b1, 1'b1, "n_fin");
        check_eq("n_cyc", 32'(cycles), 32'd5);
        check_eq("n_done", {30'd0, done, timeout}, 32'd2);
        step(1'b0, 1'b0, "n_ack");
        check_eq("n_ack_keep", {23'd0, done, cycles}, 32'd5);

        // Watchdog expiry.
        step(1'b1, 1'b0, "w_start");
        repeat (RST_CYC + 1 + TMAX) step(1'b1, 1'b0, "w_run");
        check_eq("w_to", {23'd0, timeout, cycles}, {23'd0, 1'b1, 8'd20});
        check_eq("w_en", 32'(core_en), 32'd0);
        step(1'b0, 1'b0, "w_ack");

        // Completion and limit on the same edge; then req held after done.
        step(1'b1, 1'b0, "t_start");
        repeat (RST_CYC + 1 + TMAX - 1) step(1'b1, 1'b0, "t_run");
        step(1'b1, 1'b1, "t_tie");
        check_eq("t_to", {23'd0, timeout, cycles}, {23'd0, 1'b0, 8'd20});
        repeat (10) step(1'b1, 1'b0, "h_hold");
        check_eq("h_done", 32'(done), 32'd1);
        step(1'b0, 1'b0, "h_low");

        // Ignored inputs during RST, req dropped in RUN.
        step(1'b1, 1'b1, "i_start");
        repeat (RST_CYC + 1) step(1'b1, 1'b1, "i_rst");
        check_eq("i_en", 32'(core_en), 32'd1);
        step(1'b0, 1'b1, "i_run1");
        check_eq("i_cyc", {23'd0, done, cycles}, {23'd0, 1'b1, 8'd1});
        step(1'b0, 1'b0, "i_ack");

        // Async abort in RUN cycle 3.
        step(1'b1, 1'b0, "a_start");
        repeat (RST_CYC + 1 + 2) step(1'b1, 1'b0, "a_run");
        async_reset("a_abort");
        step(1'b1, 1'b0, "a_after");
        check_eq("a_nodone", 32'(done), 32'd0);
        repeat (3) step(1'b0, 1'b0, "a_run2");
        repeat (30) step(1'b0, 1'b0, "a_flush");
        step(1'b0, 1'b0, "a_idle");

        // Randomized traffic.
        rq = 1'b0;
        for (int i = 0; i < 2500; i++) begin
            if ($urandom_range(7, 0) == 0) rq = ~rq;
            step(rq, ($urandom_range(15, 0) == 0), "rnd");
            if ($urandom_range(399, 0) == 0) async_reset("rnd_rst");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
